// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the DataMemory port arbiter: FSM encoding,
// burst length, full-word access encoding and the beat address helper.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int         BEATS     = 4;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);
  localparam logic [1:0] WORD_ACC  = 2'b00;

  // Beat addresses stay inside the aligned 16-byte line; no carry into bit 4.
  function automatic logic [31:0] beat_addr(input logic [27:0] base,
                                            input logic [1:0]  beat);
    return {base, beat, 2'b00};
  endfunction

endpackage

// File: rtl/dmem_blk_assembler.sv
// Block data path: latches the 128-bit store data at grant, selects the store
// word for the current beat, and inserts load words into the 128-bit result.
module dmem_blk_assembler
  import dmem_port_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         latch_en,
  input  logic [127:0] store_data,
  input  logic         capture_en,
  input  logic [1:0]   beat,
  input  logic [31:0]  read_word,
  output logic [127:0] load_data,
  output logic [31:0]  store_word
);

  logic [127:0] store_q;
  logic [6:0]   lane;

  assign lane = {beat, 5'd0};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; both 128-bit registers are reset because
  // load_data is a visible output that must read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q   <= '0;
      load_data <= '0;
    end else begin
      if (latch_en)   store_q <= store_data;
      if (capture_en) load_data[lane +: 32] <= read_word;
    end
  end

  assign store_word = store_q[lane +: 32];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the MEM-stage DataMemory port between single-cycle pipeline accesses
// and a non-preemptible 4-beat, 128-bit block requester with starvation guard.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         PipeMemRead,
  input  logic         PipeMemWrite,
  input  logic [31:0]  PipeAddress,
  input  logic [31:0]  PipeWriteData,
  input  logic [1:0]   PipeByteSel,
  input  logic [1:0]   PipeL16B,
  output logic         PipeStall,
  input  logic         BlkReq,
  input  logic         BlkWrite,
  input  logic [31:0]  BlkAddress,
  input  logic [127:0] BlkWriteData,
  output logic [127:0] BlkReadData,
  output logic         BlkDone,
  output logic [31:0]  MemAddress,
  output logic [31:0]  MemWriteData,
  output logic [1:0]   MemByteSel,
  output logic [1:0]   MemL16B,
  output logic         MemRead,
  output logic         MemWrite,
  input  logic [31:0]  MemReadData
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state, state_nxt;
  logic [1:0]       beat;
  logic [CNT_W-1:0] starve_cnt;
  logic [27:0]      base;
  logic             blk_write;
  logic             pipe_req;
  logic             grant;
  logic [31:0]      store_word;

  assign pipe_req = PipeMemRead | PipeMemWrite;
  assign grant    = (state == ST_IDLE) && BlkReq && (!pipe_req || starve_cnt >= LIMIT);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      beat       <= '0;
      starve_cnt <= '0;
      base       <= '0;
      blk_write  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          beat <= '0;
          if (grant) begin
            base       <= BlkAddress[31:4];
            blk_write  <= BlkWrite;
            starve_cnt <= '0;
          end else if (BlkReq) begin
            // Deferred by pipeline traffic; saturate at the limit.
            if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 1'b1;
          end else begin
            starve_cnt <= '0;
          end
        end
        ST_BURST: beat <= beat + 1'b1;
        default:  beat <= '0;
      endcase
    end
  end

  // NOTE: every output and next-state term gets a default first so no path
  // through the case leaves a value unassigned and infers a latch.
  always_comb begin
    state_nxt    = state;
    PipeStall    = 1'b0;
    BlkDone      = 1'b0;
    MemAddress   = '0;
    MemWriteData = '0;
    MemByteSel   = '0;
    MemL16B      = '0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant) begin
          state_nxt = ST_BURST;
          PipeStall = pipe_req;
        end else if (pipe_req) begin
          MemAddress   = PipeAddress;
          MemWriteData = PipeWriteData;
          MemByteSel   = PipeByteSel;
          MemL16B      = PipeL16B;
          MemRead      = PipeMemRead;
          MemWrite     = PipeMemWrite;
        end
      end
      ST_BURST: begin
        PipeStall    = 1'b1;
        MemAddress   = beat_addr(base, beat);
        MemByteSel   = WORD_ACC;
        MemL16B      = WORD_ACC;
        MemRead      = !blk_write;
        MemWrite     = blk_write;
        MemWriteData = blk_write ? store_word : '0;
        if (beat == LAST_BEAT) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        BlkDone   = 1'b1;
        PipeStall = pipe_req;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // The IDLE pass-through is combinational, so hold the port quiet while
    // reset is asserted rather than forwarding pipeline requests.
    if (Reset) begin
      PipeStall    = 1'b0;
      MemAddress   = '0;
      MemWriteData = '0;
      MemByteSel   = '0;
      MemL16B      = '0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
    end
  end

  dmem_blk_assembler u_asm (
    .clk        (Clock),
    .rst        (Reset),
    .latch_en   (grant),
    .store_data (BlkWriteData),
    .capture_en ((state == ST_BURST) && !blk_write),
    .beat       (beat),
    .read_word  (MemReadData),
    .load_data  (BlkReadData),
    .store_word (store_word)
  );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a word memory model behind the port,
// inputs driven 1 ns after the rising edge, outputs checked 1 ns later.
module tb_dmem_port_arbiter;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         PipeMemRead, PipeMemWrite;
  logic [31:0]  PipeAddress, PipeWriteData;
  logic [1:0]   PipeByteSel, PipeL16B;
  logic         PipeStall;
  logic         BlkReq, BlkWrite;
  logic [31:0]  BlkAddress;
  logic [127:0] BlkWriteData, BlkReadData;
  logic         BlkDone;
  logic [31:0]  MemAddress, MemWriteData, MemReadData;
  logic [1:0]   MemByteSel, MemL16B;
  logic         MemRead, MemWrite;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] LOAD_DATA  = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] STORE_DATA = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
  localparam logic [127:0] WRAP_DATA  = 128'h0C0C0C03_0C0C0C02_0C0C0C01_0C0C0C00;

  always #5 Clock = ~Clock;

  // Word memory with combinational read and write on the rising edge.
  logic [31:0] mem [0:1023];
  assign MemReadData = mem[MemAddress[11:2]];
  always @(posedge Clock) if (MemWrite) mem[MemAddress[11:2]] <= MemWriteData;

  dmem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .PipeMemRead  (PipeMemRead),
    .PipeMemWrite (PipeMemWrite),
    .PipeAddress  (PipeAddress),
    .PipeWriteData(PipeWriteData),
    .PipeByteSel  (PipeByteSel),
    .PipeL16B     (PipeL16B),
    .PipeStall    (PipeStall),
    .BlkReq       (BlkReq),
    .BlkWrite     (BlkWrite),
    .BlkAddress   (BlkAddress),
    .BlkWriteData (BlkWriteData),
    .BlkReadData  (BlkReadData),
    .BlkDone      (BlkDone),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemByteSel   (MemByteSel),
    .MemL16B      (MemL16B),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemReadData  (MemReadData)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pipe_idle();
    PipeMemRead   = 1'b0;
    PipeMemWrite  = 1'b0;
    PipeAddress   = '0;
    PipeWriteData = '0;
    PipeByteSel   = '0;
    PipeL16B      = '0;
  endtask

  task automatic pipe_store(input logic [31:0] addr, input logic [31:0] data);
    tick();
    pipe_idle();
    PipeMemWrite  = 1'b1;
    PipeAddress   = addr;
    PipeWriteData = data;
  endtask

  task automatic test_reset();
    Reset        = 1'b1;
    pipe_idle();
    PipeMemRead  = 1'b1;
    PipeAddress  = 32'h40;
    BlkReq       = 1'b0;
    BlkWrite     = 1'b0;
    BlkAddress   = '0;
    BlkWriteData = '0;
    #12;
    checks++;
    if ({PipeStall, BlkDone, MemRead, MemWrite, MemAddress, MemWriteData,
         MemByteSel, MemL16B, BlkReadData} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got stall=%b done=%b rd=%b wr=%b addr=%h wd=%h bs=%b l16=%b brd=%h want all 0",
               PipeStall, BlkDone, MemRead, MemWrite, MemAddress, MemWriteData,
               MemByteSel, MemL16B, BlkReadData);
    end
    Reset = 1'b0;
    pipe_idle();
  endtask

  task automatic test_pipe_only();
    for (int i = 0; i < 10; i++) begin
      tick();
      pipe_idle();
      PipeMemWrite  = 1'b1;
      PipeAddress   = 32'h40 + 32'(4 * i);
      PipeWriteData = 32'hDEADBEEF ^ 32'(i);
      PipeByteSel   = 2'(i);
      PipeL16B      = 2'(3 - (i % 4));
      #1;
      checks++;
      if ({MemWrite, MemRead, PipeStall, MemAddress, MemWriteData, MemByteSel, MemL16B} !==
          {1'b1, 1'b0, 1'b0, 32'h40 + 32'(4 * i), 32'hDEADBEEF ^ 32'(i), 2'(i), 2'(3 - (i % 4))}) begin
        errors++;
        $display("FAIL pipe_write_%0d got wr=%b rd=%b stall=%b addr=%h wd=%h bs=%b l16=%b want wr=1 rd=0 stall=0 addr=%h",
                 i, MemWrite, MemRead, PipeStall, MemAddress, MemWriteData, MemByteSel, MemL16B,
                 32'h40 + 32'(4 * i));
      end
    end
    tick();
    pipe_idle();
    PipeMemRead  = 1'b1;
    PipeMemWrite = 1'b1;
    PipeAddress  = 32'h80;
    #1;
    checks++;
    if ({MemRead, MemWrite, MemAddress, PipeStall} !== {1'b1, 1'b1, 32'h80, 1'b0}) begin
      errors++;
      $display("FAIL pipe_rd_wr_both got rd=%b wr=%b addr=%h stall=%b want 1 1 00000080 0",
               MemRead, MemWrite, MemAddress, PipeStall);
    end
    tick();
    pipe_idle();
    #1;
    checks++;
    if ({MemRead, MemWrite, PipeStall} !== 3'b000) begin
      errors++;
      $display("FAIL pipe_idle got rd=%b wr=%b stall=%b want 000", MemRead, MemWrite, PipeStall);
    end
  endtask

  task automatic test_block_load();
    for (int i = 0; i < 4; i++) pipe_store(32'h100 + 32'(4 * i), LOAD_DATA[32*i +: 32]);
    tick();
    pipe_idle();
    BlkReq     = 1'b1;
    BlkWrite   = 1'b0;
    BlkAddress = 32'h10B;
    #1;
    checks++;
    if ({MemRead, MemWrite, PipeStall, BlkDone} !== 4'b0000) begin
      errors++;
      $display("FAIL load_grant got rd=%b wr=%b stall=%b done=%b want 0000",
               MemRead, MemWrite, PipeStall, BlkDone);
    end
    for (int b = 0; b < 4; b++) begin
      tick();
      #1;
      checks++;
      if ({MemRead, MemWrite, PipeStall, BlkDone, MemAddress, MemByteSel, MemL16B} !==
          {4'b1010, 32'h100 + 32'(4 * b), 4'b0000}) begin
        errors++;
        $display("FAIL load_beat_%0d got rd=%b wr=%b stall=%b done=%b addr=%h bs=%b l16=%b want rd=1 stall=1 addr=%h",
                 b, MemRead, MemWrite, PipeStall, BlkDone, MemAddress, MemByteSel, MemL16B,
                 32'h100 + 32'(4 * b));
      end
    end
    tick();
    BlkReq = 1'b0;
    #1;
    checks++;
    if ({BlkDone, PipeStall, MemRead, MemWrite, BlkReadData} !== {4'b1000, LOAD_DATA}) begin
      errors++;
      $display("FAIL load_done got done=%b stall=%b rd=%b wr=%b data=%h want done=1 data=%h",
               BlkDone, PipeStall, MemRead, MemWrite, BlkReadData, LOAD_DATA);
    end
    tick();
    #1;
    checks++;
    if ({BlkDone, BlkReadData} !== {1'b0, LOAD_DATA}) begin
      errors++;
      $display("FAIL load_hold got done=%b data=%h want done=0 data=%h", BlkDone, BlkReadData, LOAD_DATA);
    end
  endtask

  task automatic test_block_store();
    tick();
    BlkReq       = 1'b1;
    BlkWrite     = 1'b1;
    BlkAddress   = 32'h200;
    BlkWriteData = STORE_DATA;
    #1;
    checks++;
    if ({MemRead, MemWrite, PipeStall} !== 3'b000) begin
      errors++;
      $display("FAIL store_grant got rd=%b wr=%b stall=%b want 000", MemRead, MemWrite, PipeStall);
    end
    for (int b = 0; b < 4; b++) begin
      tick();
      BlkWrite     = 1'b0;
      BlkWriteData = '1;
      #1;
      checks++;
      if ({MemRead, MemWrite, PipeStall, MemAddress, MemWriteData} !==
          {3'b011, 32'h200 + 32'(4 * b), STORE_DATA[32*b +: 32]}) begin
        errors++;
        $display("FAIL store_beat_%0d got rd=%b wr=%b stall=%b addr=%h wd=%h want rd=0 wr=1 stall=1 addr=%h wd=%h",
                 b, MemRead, MemWrite, PipeStall, MemAddress, MemWriteData,
                 32'h200 + 32'(4 * b), STORE_DATA[32*b +: 32]);
      end
    end
    tick();
    BlkReq = 1'b0;
    #1;
    checks++;
    if ({BlkDone, MemWrite, BlkReadData} !== {2'b10, LOAD_DATA}) begin
      errors++;
      $display("FAIL store_done got done=%b wr=%b data=%h want done=1 wr=0 data=%h",
               BlkDone, MemWrite, BlkReadData, LOAD_DATA);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      pipe_idle();
      PipeMemRead = 1'b1;
      PipeAddress = 32'h200 + 32'(4 * i);
      #1;
      checks++;
      if ({PipeStall, MemReadData} !== {1'b0, STORE_DATA[32*i +: 32]}) begin
        errors++;
        $display("FAIL store_readback_%0d got stall=%b rdata=%h want stall=0 rdata=%h",
                 i, PipeStall, MemReadData, STORE_DATA[32*i +: 32]);
      end
    end
    tick();
    pipe_idle();
    BlkWriteData = '0;
  endtask

  task automatic test_contention();
    tick();
    pipe_idle();
    PipeMemRead = 1'b1;
    PipeAddress = 32'h40;
    BlkReq      = 1'b1;
    BlkWrite    = 1'b0;
    BlkAddress  = 32'h100;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      #1;
      checks++;
      if ({PipeStall, MemRead, MemAddress} !== {2'b01, 32'h40}) begin
        errors++;
        $display("FAIL contend_pipe_%0d got stall=%b rd=%b addr=%h want stall=0 rd=1 addr=00000040",
                 c, PipeStall, MemRead, MemAddress);
      end
    end
    tick();
    checks++;
    if ({PipeStall, MemRead, MemAddress} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL contend_grant got stall=%b rd=%b addr=%h want stall=1 rd=0 addr=00000000",
               PipeStall, MemRead, MemAddress);
    end
    for (int b = 0; b < 4; b++) begin
      tick();
      checks++;
      if ({PipeStall, MemRead, MemAddress} !== {2'b11, 32'h100 + 32'(4 * b)}) begin
        errors++;
        $display("FAIL contend_beat_%0d got stall=%b rd=%b addr=%h want stall=1 rd=1 addr=%h",
                 b, PipeStall, MemRead, MemAddress, 32'h100 + 32'(4 * b));
      end
    end
    tick();
    BlkReq = 1'b0;
    #1;
    checks++;
    if ({BlkDone, PipeStall, MemRead} !== 3'b110) begin
      errors++;
      $display("FAIL contend_done got done=%b stall=%b rd=%b want 110", BlkDone, PipeStall, MemRead);
    end
    tick();
    checks++;
    if ({BlkDone, PipeStall, MemRead, MemAddress, BlkReadData} !== {3'b001, 32'h40, LOAD_DATA}) begin
      errors++;
      $display("FAIL contend_resume got done=%b stall=%b rd=%b addr=%h data=%h want 0 0 1 00000040 %h",
               BlkDone, PipeStall, MemRead, MemAddress, BlkReadData, LOAD_DATA);
    end
    tick();
    pipe_idle();
  endtask

  task automatic test_burst_pipe_arrives();
    tick();
    pipe_idle();
    BlkReq       = 1'b1;
    BlkWrite     = 1'b1;
    BlkAddress   = 32'hFFFF_FFF7;
    BlkWriteData = WRAP_DATA;
    #1;
    checks++;
    if ({PipeStall, MemRead, MemWrite} !== 3'b000) begin
      errors++;
      $display("FAIL arrive_grant got stall=%b rd=%b wr=%b want 000", PipeStall, MemRead, MemWrite);
    end
    for (int b = 0; b < 4; b++) begin
      tick();
      PipeMemRead = 1'b1;
      PipeAddress = 32'h40;
      #1;
      checks++;
      if ({PipeStall, MemRead, MemWrite, MemAddress, MemWriteData} !==
          {3'b101, 32'hFFFF_FFF0 + 32'(4 * b), WRAP_DATA[32*b +: 32]}) begin
        errors++;
        $display("FAIL arrive_beat_%0d got stall=%b rd=%b wr=%b addr=%h wd=%h want 1 0 1 addr=%h wd=%h",
                 b, PipeStall, MemRead, MemWrite, MemAddress, MemWriteData,
                 32'hFFFF_FFF0 + 32'(4 * b), WRAP_DATA[32*b +: 32]);
      end
    end
    tick();
    BlkReq = 1'b0;
    #1;
    checks++;
    if ({BlkDone, PipeStall, MemRead, MemWrite} !== 4'b1100) begin
      errors++;
      $display("FAIL arrive_done got done=%b stall=%b rd=%b wr=%b want 1100",
               BlkDone, PipeStall, MemRead, MemWrite);
    end
    tick();
    checks++;
    if ({PipeStall, MemRead, MemAddress} !== {2'b01, 32'h40}) begin
      errors++;
      $display("FAIL arrive_resume got stall=%b rd=%b addr=%h want 0 1 00000040",
               PipeStall, MemRead, MemAddress);
    end
    tick();
    PipeAddress = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (MemReadData !== WRAP_DATA[127:96]) begin
      errors++;
      $display("FAIL wrap_readback got %h want %h", MemReadData, WRAP_DATA[127:96]);
    end
    tick();
    pipe_idle();
    BlkWriteData = '0;
  endtask

  task automatic test_reset_mid_burst();
    tick();
    BlkReq     = 1'b1;
    BlkWrite   = 1'b0;
    BlkAddress = 32'h200;
    for (int b = 0; b < 3; b++) tick();
    checks++;
    if ({MemRead, MemAddress} !== {1'b1, 32'h208}) begin
      errors++;
      $display("FAIL midrst_beat2 got rd=%b addr=%h want rd=1 addr=00000208", MemRead, MemAddress);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if ({PipeStall, BlkDone, MemRead, MemWrite, MemAddress, MemWriteData,
         MemByteSel, MemL16B, BlkReadData} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got stall=%b done=%b rd=%b wr=%b addr=%h brd=%h want all 0",
               PipeStall, BlkDone, MemRead, MemWrite, MemAddress, BlkReadData);
    end
    tick();
    Reset = 1'b0;
    #1;
    checks++;
    if ({MemRead, MemWrite, PipeStall, BlkDone} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_regrant got rd=%b wr=%b stall=%b done=%b want 0000",
               MemRead, MemWrite, PipeStall, BlkDone);
    end
    for (int b = 0; b < 4; b++) begin
      tick();
      checks++;
      if ({MemRead, PipeStall, MemAddress} !== {2'b11, 32'h200 + 32'(4 * b)}) begin
        errors++;
        $display("FAIL midrst_beat_%0d got rd=%b stall=%b addr=%h want 1 1 %h",
                 b, MemRead, PipeStall, MemAddress, 32'h200 + 32'(4 * b));
      end
    end
    tick();
    BlkReq = 1'b0;
    #1;
    checks++;
    if ({BlkDone, BlkReadData} !== {1'b1, STORE_DATA}) begin
      errors++;
      $display("FAIL midrst_done got done=%b data=%h want done=1 data=%h", BlkDone, BlkReadData, STORE_DATA);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_block_load();
    test_block_store();
    test_contention();
    test_burst_pipe_arrives();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
